// File: rtl/ram_bus_arbiter.sv
// Arbitrates the shared serial-RAM SPI bus between MCU and Coprocessor; optional holder timeout under ARB_TIMEOUT_EN.
// Latency: request to grant 3 clocks from IDLE; release to next grant 3 + GUARD_CYCLES clocks.
// Backpressure: a holder keeps the bus while its request or its chip select is active; others wait at their level request.
module ram_bus_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic nreset,
  input  logic mcu_req,
  input  logic cop_req,
  input  logic mcu_nss,
  input  logic cop_nss,
  output logic bus_mode,
  output logic mcu_grant,
  output logic cop_grant,
  output logic ram_gate,
  output logic preempt
);

  typedef enum logic [1:0] {S_IDLE, S_GNT_MCU, S_GNT_COP, S_GUARD} state_t;

  // Synchronizer stages, bit order {cop_nss, mcu_nss, cop_req, mcu_req}
  logic [3:0] meta_q;
  logic [3:0] sync_q;
  logic       mcu_req_s, cop_req_s, mcu_nss_s, cop_nss_s;

  state_t     state_q;
  logic       last_cop_q;   // last owner: 1 = COP, 0 = MCU
  logic [3:0] guard_cnt_q;
  logic       bus_mode_q, mcu_grant_q, cop_grant_q, ram_gate_q, preempt_q;

  logic       pick_mcu, pick_cop, guard_done, to_hit;

  // Two-flop synchronizers; chip selects rest high (deselected)
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_q <= 4'b1100;
      sync_q <= 4'b1100;
    end else begin
      meta_q <= {cop_nss, mcu_nss, cop_req, mcu_req};
      sync_q <= meta_q;
    end
  end

  assign mcu_req_s = sync_q[0];
  assign cop_req_s = sync_q[1];
  assign mcu_nss_s = sync_q[2];
  assign cop_nss_s = sync_q[3];

  // Grant choice shared by IDLE and guard expiry: a lone requester wins, a tie goes to the non-last owner
  always_comb begin
    pick_mcu   = mcu_req_s && (!cop_req_s || last_cop_q);
    pick_cop   = cop_req_s && !pick_mcu;
    guard_done = (guard_cnt_q == 4'(GUARD_CYCLES - 1));
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        to_run;

  // Timeout runs only while the holder is idle on the bus and the other master waits
  always_comb begin
    to_run = ((state_q == S_GNT_MCU) && mcu_nss_s && cop_req_s) ||
             ((state_q == S_GNT_COP) && cop_nss_s && mcu_req_s);
    to_hit = to_run && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  end

  // Saturating idle-holder counter, cleared whenever the run condition lapses
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      to_cnt_q <= 16'd0;
    end else if (!to_run || to_hit) begin
      to_cnt_q <= 16'd0;
    end else if (to_cnt_q != 16'hFFFF) begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end
  end
`else
  logic unused_timeout;
  assign to_hit         = 1'b0;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  // Ownership FSM with registered outputs; grants and bus_mode move on the same edge
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      last_cop_q  <= 1'b1;
      guard_cnt_q <= 4'd0;
      bus_mode_q  <= 1'b0;
      mcu_grant_q <= 1'b0;
      cop_grant_q <= 1'b0;
      ram_gate_q  <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        S_IDLE, S_GUARD: begin
          if (state_q == S_GUARD && !guard_done) begin
            guard_cnt_q <= guard_cnt_q + 4'd1;
          end else if (pick_mcu) begin
            state_q     <= S_GNT_MCU;
            bus_mode_q  <= 1'b0;
            mcu_grant_q <= 1'b1;
            ram_gate_q  <= 1'b1;
          end else if (pick_cop) begin
            state_q     <= S_GNT_COP;
            bus_mode_q  <= 1'b1;
            cop_grant_q <= 1'b1;
            ram_gate_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GNT_MCU: begin
          // A normal release takes priority; the timeout fires even with the request still high
          if ((!mcu_req_s && mcu_nss_s) || to_hit) begin
            state_q     <= S_GUARD;
            guard_cnt_q <= 4'd0;
            last_cop_q  <= 1'b0;
            mcu_grant_q <= 1'b0;
            ram_gate_q  <= 1'b0;
            preempt_q   <= mcu_req_s || !mcu_nss_s;
          end
        end
        S_GNT_COP: begin
          if ((!cop_req_s && cop_nss_s) || to_hit) begin
            state_q     <= S_GUARD;
            guard_cnt_q <= 4'd0;
            last_cop_q  <= 1'b1;
            cop_grant_q <= 1'b0;
            ram_gate_q  <= 1'b0;
            preempt_q   <= cop_req_s || !cop_nss_s;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_mode  = bus_mode_q;
  assign mcu_grant = mcu_grant_q;
  assign cop_grant = cop_grant_q;
  assign ram_gate  = ram_gate_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter: stimulus pushes the expected output vector and cycle of each change,
// a monitor pops and compares whenever the DUT outputs change. Vector = {bus_mode, mcu_grant, cop_grant, ram_gate, preempt}.
module tb_ram_bus_arbiter;

  logic clk = 1'b0;
  logic nreset, mcu_req, cop_req, mcu_nss, cop_nss;
  logic bus_mode, mcu_grant, cop_grant, ram_gate, preempt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         at;
    logic [4:0] val;
    string      name;
  } exp_t;
  exp_t sb[$];

  ram_bus_arbiter #(.GUARD_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .nreset(nreset),
    .mcu_req(mcu_req), .cop_req(cop_req),
    .mcu_nss(mcu_nss), .cop_nss(cop_nss),
    .bus_mode(bus_mode), .mcu_grant(mcu_grant), .cop_grant(cop_grant),
    .ram_gate(ram_gate), .preempt(preempt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] outs();
    return {bus_mode, mcu_grant, cop_grant, ram_gate, preempt};
  endfunction

  task automatic push(input int at, input logic [4:0] val, input string name);
    exp_t e;
    e.at = at; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [4:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, outs(), exp, cyc);
    end
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: exclusivity every cycle, scoreboard pop on every output change
  logic [4:0] prev = 5'b0;
  always @(negedge clk) begin
    logic [4:0] o;
    exp_t e;
    o = outs();
    checks++;
    if ((mcu_grant && cop_grant) || (ram_gate !== (mcu_grant | cop_grant))) begin
      errors++;
      $display("FAIL grant_exclusive: got %b at cycle %0d, expected one grant at most and ram_gate = OR of grants", o, cyc);
    end
    if (o !== prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %b at cycle %0d, expected no change from %b", o, cyc, prev);
      end else begin
        e = sb.pop_front();
        if (e.val !== o || e.at != cyc) begin
          errors++;
          $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d", e.name, o, cyc, e.val, e.at);
        end
      end
      prev = o;
    end
  end

  initial begin
    nreset = 1'b0; mcu_req = 1'b0; cop_req = 1'b0; mcu_nss = 1'b1; cop_nss = 1'b1;
    negs(3);
    check_now("reset_hold", 5'b00000);
    nreset = 1'b1;
    negs(2);
    check_now("reset_values", 5'b00000);

    // Tie from reset: MCU wins; release hands to COP after 4 guard clocks
    mcu_req = 1'b1; cop_req = 1'b1;
    push(cyc + 3, 5'b01010, "tie_mcu_wins");
    negs(6);
    mcu_req = 1'b0;
    push(cyc + 3, 5'b00000, "mcu_release");
    push(cyc + 7, 5'b10110, "guard_to_cop");
    negs(10);

    // COP mid-transaction keeps the grant after dropping its request
    cop_nss = 1'b0;
    negs(2);
    cop_req = 1'b0;
    negs(8);
    check_now("cop_held_by_nss", 5'b10110);
    cop_nss = 1'b1;
    push(cyc + 3, 5'b10000, "cop_release_after_nss");
    negs(10);

    // MCU-only request from IDLE
    mcu_req = 1'b1;
    push(cyc + 3, 5'b01010, "mcu_only_grant");
    negs(6);

    // COP waits while MCU idles on the bus
    cop_req = 1'b1;
`ifdef ARB_TIMEOUT_EN
    push(cyc + 18, 5'b00001, "preempt_pulse");
    push(cyc + 19, 5'b00000, "preempt_end");
    push(cyc + 22, 5'b10110, "cop_after_preempt");
    negs(19);
    mcu_req = 1'b0;
    negs(11);
`else
    negs(40);
    check_now("mcu_keeps_bus", 5'b01010);
    mcu_req = 1'b0;
    push(cyc + 3, 5'b00000, "mcu_release2");
    push(cyc + 7, 5'b10110, "cop_after_guard");
    negs(10);
`endif

    // Async reset during GNT_COP, then COP-only grant in 3 clocks
    negs(3);
    push(cyc + 1, 5'b00000, "async_reset_drop");
    #1 nreset = 1'b0;
    #1 check_now("reset_immediate", 5'b00000);
    negs(3);
    nreset = 1'b1;
    push(cyc + 3, 5'b10110, "cop_after_reset");
    negs(6);
    cop_req = 1'b0;
    push(cyc + 3, 5'b10000, "cop_release3");
    negs(10);

    // Sub-cycle pulse is never sampled
    mcu_req = 1'b1;
    #2 mcu_req = 1'b0;
    negs(8);
    check_now("short_pulse_ignored", 5'b10000);

    // Two-clock request is granted, then released
    mcu_req = 1'b1;
    push(cyc + 3, 5'b01010, "two_clock_req_grant");
    push(cyc + 5, 5'b00000, "two_clock_req_release");
    negs(2);
    mcu_req = 1'b0;
    negs(12);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      while (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("FAIL %s: got no change by cycle %0d, expected %b at cycle %0d", e.name, cyc, e.val, e.at);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
